// File: rtl/seg7_pkg.sv
// Shared segment encodings, conversion FSM states and the BCD-to-segment lookup
// for the signed seven-segment display.
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;
  localparam logic [6:0] SEG_E     = 7'b0000110;

  typedef enum logic [1:0] {IDLE, CONVERT, COMMIT} conv_state_t;

  // Segment order is {g,f,e,d,c,b,a}, active-low; invalid BCD codes show E.
  function automatic logic [6:0] digit_to_seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0011000;
      default: s = SEG_E;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg7_bcd_converter.sv
// Sequential binary-to-BCD converter (double dabble), one iteration per clock,
// followed by a single COMMIT cycle in which bcd holds the final result.
module seg7_bcd_converter
  import seg7_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NBCD  = (WIDTH * 301) / 1000 + 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [WIDTH-1:0]    bin,
  output logic                busy,
  output logic                done,
  output logic [4*NBCD-1:0]   bcd
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int SW = 4 * NBCD + WIDTH;

  conv_state_t   state, state_next;
  logic [SW-1:0] shreg;
  logic [SW-1:0] adj;
  logic [CW-1:0] iter;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = CONVERT;
      CONVERT: if (iter == CW'(WIDTH - 1)) state_next = COMMIT;
      COMMIT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
    done = (state == COMMIT);
  end

  // Every BCD nibble of 5 or more is corrected by +3 before the shift.
  always_comb begin
    adj = shreg;
    for (int i = 0; i < NBCD; i++) begin
      if (adj[WIDTH + 4*i +: 4] >= 4'd5)
        adj[WIDTH + 4*i +: 4] = adj[WIDTH + 4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg <= '0;
      iter  <= '0;
    end else if (state == IDLE && start) begin
      shreg <= {{(4*NBCD){1'b0}}, bin};
      iter  <= '0;
    end else if (state == CONVERT) begin
      shreg <= {adj[SW-2:0], 1'b0};
      iter  <= iter + CW'(1);
    end
  end

  assign bcd = shreg[SW-1:WIDTH];

endmodule

// File: rtl/seg7_signed_display.sv
// Multiplexed seven-segment driver for a signed value: sign/magnitude capture,
// digit formatting (blanking, minus, overflow) and the anode scan.
module seg7_signed_display
  import seg7_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 100000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  value,
  input  logic              load,
  output logic              busy,
  output logic              overflow,
  output logic [DIGITS-1:0] an,
  output logic [6:0]        seg
);

  localparam int NBCD = (WIDTH * 301) / 1000 + 1;
  localparam int MAXD = (DIGITS > NBCD) ? DIGITS : NBCD;
  localparam int RW   = $clog2(REFRESH_DIV);
  localparam int IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic                 conv_busy;
  logic                 conv_done;
  logic [4*NBCD-1:0]    bcd;
  logic [4*MAXD-1:0]    bcd_pad;
  logic [WIDTH-1:0]     mag;
  logic                 sign_q;
  logic                 ovf_q;
  int                   nsig;
  logic                 fmt_ovf;
  logic [6:0]           fmt_codes [DIGITS];
  logic [6:0]           disp      [DIGITS];
  logic [6:0]           disp_next [DIGITS];
  logic [RW-1:0]        cnt;
  logic [IW-1:0]        idx;
  logic [IW-1:0]        idx_next;
  logic                 wrap;

  // Negating the most negative value wraps back to 2^(WIDTH-1), which is the
  // correct unsigned magnitude.
  assign mag = value[WIDTH-1] ? (~value + {{(WIDTH-1){1'b0}}, 1'b1}) : value;

  seg7_bcd_converter #(
    .WIDTH (WIDTH),
    .NBCD  (NBCD)
  ) u_conv (
    .clk   (clk),
    .rst   (rst),
    .start (load),
    .bin   (mag),
    .busy  (conv_busy),
    .done  (conv_done),
    .bcd   (bcd)
  );

  assign busy     = conv_busy;
  assign overflow = ovf_q;
  assign bcd_pad  = (4*MAXD)'(bcd);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      sign_q <= 1'b0;
    else if (load && !conv_busy)  sign_q <= value[WIDTH-1];
  end

  // A zero value still counts one significant digit so that "0" is shown.
  always_comb begin
    nsig = 1;
    for (int i = 0; i < NBCD; i++) begin
      if (bcd_pad[4*i +: 4] != 4'd0) nsig = i + 1;
    end
    fmt_ovf = (nsig + int'(sign_q)) > DIGITS;
    for (int i = 0; i < DIGITS; i++) begin
      fmt_codes[i] = SEG_BLANK;
      if (fmt_ovf)                  fmt_codes[i] = SEG_E;
      else if (i < nsig)            fmt_codes[i] = digit_to_seg(bcd_pad[4*i +: 4]);
      else if (i == nsig && sign_q) fmt_codes[i] = SEG_MINUS;
    end
  end

  always_comb begin
    for (int i = 0; i < DIGITS; i++) begin
      disp_next[i] = conv_done ? fmt_codes[i] : disp[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
        disp[i] <= (i == 0) ? digit_to_seg(4'd0) : SEG_BLANK;
      end
    end else if (conv_done) begin
      ovf_q <= fmt_ovf;
      for (int i = 0; i < DIGITS; i++) begin
        disp[i] <= fmt_codes[i];
      end
    end
  end

  assign wrap = (cnt == RW'(REFRESH_DIV - 1));

  always_comb begin
    idx_next = idx;
    if (wrap) idx_next = (idx == IW'(DIGITS - 1)) ? '0 : idx + IW'(1);
  end

  // an and seg are both derived from next-cycle state so they always switch together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      idx <= '0;
      an  <= '1;
      seg <= SEG_BLANK;
    end else begin
      cnt <= wrap ? '0 : cnt + RW'(1);
      idx <= idx_next;
      an  <= ~(DIGITS'(1) << idx_next);
      seg <= disp_next[idx_next];
    end
  end

endmodule
